// File: rtl/wheel_speed_meter_pkg.sv
// rtl/wheel_speed_meter_pkg.sv - shared speed-bus widths, limits and clock constants
package wheel_speed_meter_pkg;

   localparam int SPEED_W             = 16;
   localparam int SPEED_MAX_DEF       = 99;
   localparam int CLK_HZ              = 50_000_000;
   localparam int GATE_CYCLES_DEF     = CLK_HZ;
   localparam int DEBOUNCE_CYCLES_DEF = 1_000;

   localparam logic [SPEED_W-1:0] CNT_SAT = '1;

   // Clamp a wide scaled count to the display ceiling.
   function automatic logic [SPEED_W-1:0] saturate_speed(input logic [31:0] prod, input int max_val);
      return (prod > 32'(max_val)) ? SPEED_W'(max_val) : prod[SPEED_W-1:0];
   endfunction

endpackage

// File: rtl/wheel_speed_meter_pulse_debouncer.sv
// rtl/wheel_speed_meter_pulse_debouncer.sv - 2-flop sync, hold-time debounce and rising-edge strobe
module pulse_debouncer
   import wheel_speed_meter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, rise_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          flip;

   // The level only moves once the synced input has disagreed for the full hold time.
   assign flip = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if ((sync2_q == level_q) || flip) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         rise_q  <= flip && sync2_q;
         if (flip) begin
            level_q <= sync2_q;
         end
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/wheel_speed_meter.sv
// rtl/wheel_speed_meter.sv - wheel pulse rate over a gate window, scaled and saturated onto the speed bus
module wheel_speed_meter
   import wheel_speed_meter_pkg::*;
#(
   parameter int GATE_CYCLES     = GATE_CYCLES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int MULT            = 1,
   parameter int SPEED_MAX       = SPEED_MAX_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               wheel_pulse,
   output logic [SPEED_W-1:0] speed,
   output logic               speed_valid,
   output logic               overflow
);

   localparam int TW = $clog2(GATE_CYCLES + 1);

   logic               deb_level_unused;
   logic               rise;
   logic [TW-1:0]      timer_q;
   logic [SPEED_W-1:0] cnt_q, cnt_d;
   logic [SPEED_W-1:0] speed_q;
   logic               valid_q, overflow_q;
   logic               latch;
   logic [SPEED_W:0]   tot;
   logic [31:0]        prod;

   pulse_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk  (clk),
      .rst  (rst),
      .din  (wheel_pulse),
      .level(deb_level_unused),
      .rise (rise)
   );

   assign latch = (timer_q == TW'(GATE_CYCLES - 1));
   // A rise landing in the latch cycle still belongs to the closing window.
   assign tot   = {1'b0, cnt_q} + (SPEED_W + 1)'(rise);
   assign prod  = 32'(tot) * 32'(MULT);

   always_comb begin
      cnt_d = cnt_q;
      if (rise && (cnt_q != CNT_SAT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_q    <= '0;
         cnt_q      <= '0;
         speed_q    <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else if (!en) begin
         timer_q    <= '0;
         cnt_q      <= '0;
         speed_q    <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         valid_q <= latch;
         if (latch) begin
            timer_q    <= '0;
            cnt_q      <= '0;
            speed_q    <= saturate_speed(prod, SPEED_MAX);
            overflow_q <= (prod > 32'(SPEED_MAX));
         end else begin
            timer_q <= timer_q + 1'b1;
            cnt_q   <= cnt_d;
         end
      end
   end

   assign speed       = speed_q;
   assign speed_valid = valid_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_wheel_speed_meter.sv
// tb/tb_wheel_speed_meter.sv - directed bench: a 100-cycle-window meter and a long-window x2 meter
module tb_wheel_speed_meter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_a, en_b;
   logic        wheel_a, wheel_b;
   logic [15:0] speed_a, speed_b;
   logic        valid_a, valid_b;
   logic        ovf_a, ovf_b;
   int          total = 0;
   int          bad   = 0;
   int          strobes;

   always #5 clk = ~clk;

   wheel_speed_meter #(
      .GATE_CYCLES(100), .DEBOUNCE_CYCLES(4), .MULT(1), .SPEED_MAX(99)
   ) u_dut_a (
      .clk(clk), .rst(rst), .en(en_a), .wheel_pulse(wheel_a),
      .speed(speed_a), .speed_valid(valid_a), .overflow(ovf_a)
   );

   // Long window so that dozens of clean pulses fit in one measurement.
   wheel_speed_meter #(
      .GATE_CYCLES(1600), .DEBOUNCE_CYCLES(4), .MULT(2), .SPEED_MAX(99)
   ) u_dut_b (
      .clk(clk), .rst(rst), .en(en_b), .wheel_pulse(wheel_b),
      .speed(speed_b), .speed_valid(valid_b), .overflow(ovf_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulses(input bit sel_b, input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         if (sel_b) wheel_b = 1'b1; else wheel_a = 1'b1;
         tick(hi);
         if (sel_b) wheel_b = 1'b0; else wheel_a = 1'b0;
         tick(lo);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; en_a = 1'b0; en_b = 1'b0; wheel_a = 1'b0; wheel_b = 1'b0;
      tick(3);
      check("rst_speed_a", 32'(speed_a), 0);
      check("rst_valid_a", 32'(valid_a), 0);
      check("rst_ovf_a",   32'(ovf_a),   0);
      check("rst_speed_b", 32'(speed_b), 0);

      // 7 clean pulses, strobe exactly 100 cycles after enable
      rst = 1'b1; en_a = 1'b1;
      pulses(1'b0, 7, 6, 6);
      tick(15);
      check("t1_no_early_strobe", 32'(valid_a), 0);
      tick(1);
      check("t1_valid", 32'(valid_a), 1);
      check("t1_speed", 32'(speed_a), 7);
      check("t1_ovf",   32'(ovf_a),   0);
      tick(1);
      check("t1_valid_one_cycle", 32'(valid_a), 0);
      check("t1_speed_hold",      32'(speed_a), 7);

      // glitches of 1..3 cycles never reach the debounced level
      wheel_a = 1'b1; tick(1); wheel_a = 1'b0; tick(5);
      wheel_a = 1'b1; tick(2); wheel_a = 1'b0; tick(5);
      wheel_a = 1'b1; tick(3); wheel_a = 1'b0; tick(5);
      tick(77);
      check("t2_hold_before", 32'(speed_a), 7);
      tick(1);
      check("t2_valid", 32'(valid_a), 1);
      check("t2_speed", 32'(speed_a), 0);

      // second rise lands in the latch cycle
      pulses(1'b0, 1, 6, 6);
      tick(81);
      wheel_a = 1'b1;
      tick(7);
      check("t4_valid", 32'(valid_a), 1);
      check("t4_speed_latch_rise", 32'(speed_a), 2);
      wheel_a = 1'b0;
      tick(6);
      pulses(1'b0, 4, 6, 6);
      tick(46);
      check("t4_next_valid", 32'(valid_a), 1);
      check("t4_next_window", 32'(speed_a), 4);

      // enable dropped mid-window, then a fresh window
      pulses(1'b0, 3, 6, 6);
      en_a = 1'b0;
      tick(1);
      check("t5_speed_cleared", 32'(speed_a), 0);
      check("t5_ovf_cleared",   32'(ovf_a),   0);
      check("t5_no_valid",      32'(valid_a), 0);
      strobes = 0;
      for (int i = 0; i < 150; i++) begin
         tick(1);
         if (valid_a) strobes++;
      end
      check("t5_no_strobe_while_off", 32'(strobes), 0);
      en_a = 1'b1;
      tick(99);
      check("t5_no_early_strobe", 32'(valid_a), 0);
      tick(1);
      check("t5_first_strobe", 32'(valid_a), 1);
      check("t5_speed", 32'(speed_a), 0);

      // x2 scale: 60 pulses saturate, 5 pulses give 10
      en_b = 1'b1;
      pulses(1'b1, 60, 10, 10);
      tick(399);
      check("t3_no_early_strobe", 32'(valid_b), 0);
      tick(1);
      check("t3_valid", 32'(valid_b), 1);
      check("t3_speed_sat", 32'(speed_b), 99);
      check("t3_ovf", 32'(ovf_b), 1);
      pulses(1'b1, 5, 10, 10);
      tick(1500);
      check("t3b_valid", 32'(valid_b), 1);
      check("t3b_speed", 32'(speed_b), 10);
      check("t3b_ovf", 32'(ovf_b), 0);

      // reach 42, then reset mid-window
      pulses(1'b1, 21, 10, 10);
      tick(1180);
      check("t6_speed_42", 32'(speed_b), 42);
      check("t6_ovf", 32'(ovf_b), 0);
      pulses(1'b1, 3, 10, 10);
      tick(5);
      rst = 1'b0;
      #1;
      check("t6_async_speed", 32'(speed_b), 0);
      check("t6_async_ovf",   32'(ovf_b),   0);
      check("t6_async_valid", 32'(valid_b), 0);
      tick(2);
      check("t6_held_speed", 32'(speed_b), 0);
      rst = 1'b1;
      pulses(1'b1, 2, 10, 10);
      tick(1559);
      check("t6_no_early_strobe", 32'(valid_b), 0);
      tick(1);
      check("t6_valid", 32'(valid_b), 1);
      check("t6_post_reset_speed", 32'(speed_b), 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
